// File: rtl/port_zone_bridge.sv
// port_zone_bridge: 68K PORT zone to memory-arbiter req/ack bridge; optional PORT_TIMEOUT_EN adds a forced-completion watchdog
module port_zone_bridge #(
  parameter int          ADDR_W  = 19,
  parameter int          TIMEOUT = 1023,
  parameter logic [15:0] TO_DATA = 16'hFFFF
) (
  input  logic              CLK,
  input  logic              nRESET,
  input  logic              nAS,
  input  logic              RW,
  input  logic              nUDS,
  input  logic              nLDS,
  input  logic              nPORT_ZONE,
  input  logic [ADDR_W-1:0] M68K_ADDR,
  input  logic [15:0]       M68K_DATA_IN,
  output logic [15:0]       PORT_DATA_OUT,
  output logic              MEM_REQ,
  output logic              MEM_WE,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic [15:0]       MEM_WDATA,
  output logic [1:0]        MEM_BE,
  input  logic              MEM_ACK,
  input  logic [15:0]       MEM_RDATA,
  output logic              PDTACK,
  output logic              nPWAIT0,
  output logic              nPWAIT1,
  output logic              TIMEOUT_ERR
);
  typedef enum logic [2:0] {IDLE, REQ, WAIT_ACK, HOLD, ABORT} state_t;
  state_t state, state_nx;
  logic [1:0] as_q, rw_q, uds_q, lds_q, zone_q;
  logic as_s, rw_s, uds_s, lds_s, zone_s;
  logic start, waiting, ack_live, to_hit;
  assign as_s     = as_q[1];
  assign rw_s     = rw_q[1];
  assign uds_s    = uds_q[1];
  assign lds_s    = lds_q[1];
  assign zone_s   = zone_q[1];
  assign start    = (state == IDLE) & ~as_s & ~zone_s & (~uds_s | ~lds_s);
  assign waiting  = (state == WAIT_ACK) | (state == ABORT);
  assign ack_live = MEM_ACK & ((state == REQ) | (state == WAIT_ACK));
  // two-flop synchronisers for the asynchronous 68K bus controls (idle-high)
  always_ff @(posedge CLK or negedge nRESET)
    if (!nRESET) begin
      as_q   <= 2'b11;
      rw_q   <= 2'b11;
      uds_q  <= 2'b11;
      lds_q  <= 2'b11;
      zone_q <= 2'b11;
    end else begin
      as_q   <= {as_q[0], nAS};
      rw_q   <= {rw_q[0], RW};
      uds_q  <= {uds_q[0], nUDS};
      lds_q  <= {lds_q[0], nLDS};
      zone_q <= {zone_q[0], nPORT_ZONE};
    end
`ifdef PORT_TIMEOUT_EN
  logic [9:0] cnt;
  // watchdog counts WAIT_ACK/ABORT cycles, restarting with every new request
  always_ff @(posedge CLK or negedge nRESET)
    if (!nRESET) cnt <= '0;
    else if (start) cnt <= '0;
    else if (waiting) cnt <= cnt + 10'd1;
  assign to_hit = waiting & ~MEM_ACK & (cnt == 10'(TIMEOUT - 1));
`else
  assign to_hit = 1'b0;
`endif
  // state register
  always_ff @(posedge CLK or negedge nRESET)
    if (!nRESET) state <= IDLE;
    else state <= state_nx;
  // next state: an ack always beats a simultaneous nAS release
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:     state_nx = start ? REQ : IDLE;
      REQ:      state_nx = MEM_ACK ? HOLD : WAIT_ACK;
      WAIT_ACK: state_nx = (MEM_ACK | to_hit) ? HOLD : as_s ? ABORT : WAIT_ACK;
      HOLD:     state_nx = as_s ? IDLE : HOLD;
      ABORT:    state_nx = (MEM_ACK | to_hit) ? IDLE : ABORT;
      default:  state_nx = IDLE;
    endcase
  end
  // bus-facing outputs decoded from the registered state
  always_comb begin
    MEM_REQ = (state == REQ) | waiting;
    PDTACK  = state == HOLD;
    nPWAIT1 = 1'b1;
    nPWAIT0 = ~MEM_REQ;
  end
  // request attributes latched at start; read data only from live read acks or a read timeout
  always_ff @(posedge CLK or negedge nRESET)
    if (!nRESET) begin
      MEM_ADDR      <= '0;
      MEM_WE        <= 1'b0;
      MEM_BE        <= 2'b00;
      MEM_WDATA     <= '0;
      PORT_DATA_OUT <= '0;
      TIMEOUT_ERR   <= 1'b0;
    end else begin
      if (start) begin
        MEM_ADDR <= M68K_ADDR;
        MEM_WE   <= ~rw_s;
        MEM_BE   <= {~uds_s, ~lds_s};
        if (!rw_s) MEM_WDATA <= M68K_DATA_IN;
      end
      if (ack_live & ~MEM_WE) PORT_DATA_OUT <= MEM_RDATA;
      else if (to_hit & (state == WAIT_ACK) & ~MEM_WE) PORT_DATA_OUT <= TO_DATA;
      TIMEOUT_ERR <= to_hit;
    end
endmodule

// File: tb/tb_port_zone_bridge.sv
// tb_port_zone_bridge: directed self-checking bench for port_zone_bridge
module tb_port_zone_bridge;
  logic        clk = 1'b0;
  logic        nreset = 1'b0;
  logic        nas = 1'b1, rw = 1'b1, nuds = 1'b1, nlds = 1'b1, nzone = 1'b1;
  logic [18:0] addr = '0;
  logic [15:0] din = '0;
  logic [15:0] dout;
  logic        mem_req, mem_we;
  logic [18:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [1:0]  mem_be;
  logic        mem_ack = 1'b0;
  logic [15:0] mem_rdata = '0;
  logic        pdtack, npwait0, npwait1, to_err;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  port_zone_bridge #(.ADDR_W(19), .TIMEOUT(8), .TO_DATA(16'hFFFF)) dut (
    .CLK(clk), .nRESET(nreset), .nAS(nas), .RW(rw), .nUDS(nuds), .nLDS(nlds),
    .nPORT_ZONE(nzone), .M68K_ADDR(addr), .M68K_DATA_IN(din),
    .PORT_DATA_OUT(dout), .MEM_REQ(mem_req), .MEM_WE(mem_we), .MEM_ADDR(mem_addr),
    .MEM_WDATA(mem_wdata), .MEM_BE(mem_be), .MEM_ACK(mem_ack), .MEM_RDATA(mem_rdata),
    .PDTACK(pdtack), .nPWAIT0(npwait0), .nPWAIT1(npwait1), .TIMEOUT_ERR(to_err)
  );

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus_release();
    nas = 1'b1; nuds = 1'b1; nlds = 1'b1; nzone = 1'b1; rw = 1'b1;
  endtask

  task automatic test_reset();
    nreset = 1'b0;
    tick(2);
    checks++;
    if ({mem_req, mem_we, mem_addr, mem_wdata, mem_be, pdtack, dout, npwait1, npwait0, to_err} !==
        {1'b0, 1'b0, 19'd0, 16'd0, 2'b00, 1'b0, 16'd0, 1'b1, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL reset_values got req=%b we=%b addr=%h wd=%h be=%b pdt=%b dout=%h w1=%b w0=%b to=%b",
               mem_req, mem_we, mem_addr, mem_wdata, mem_be, pdtack, dout, npwait1, npwait0, to_err);
    end
    #2 nreset = 1'b1;
    tick(2);
  endtask

  task automatic test_read();
    addr = 19'd1; rw = 1'b1; nuds = 1'b0; nlds = 1'b0; nzone = 1'b0; nas = 1'b0;
    tick(2);
    checks++;
    if (mem_req !== 1'b0) begin failures++; $display("FAIL read_req_edge2 got=%b exp=0", mem_req); end
    tick();
    checks++;
    if ({mem_req, mem_be, mem_we, mem_addr, npwait1, npwait0} !== {1'b1, 2'b11, 1'b0, 19'd1, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL read_req_edge3 got req=%b be=%b we=%b addr=%h w=%b%b exp 1 11 0 00001 10",
               mem_req, mem_be, mem_we, mem_addr, npwait1, npwait0);
    end
    tick(4);
    checks++;
    if ({mem_req, pdtack} !== 2'b10) begin failures++; $display("FAIL read_wait got req/pdt=%b exp=10", {mem_req, pdtack}); end
    mem_ack = 1'b1; mem_rdata = 16'h1234;
    tick();
    mem_ack = 1'b0; mem_rdata = 16'h0000;
    checks++;
    if ({pdtack, mem_req, dout, npwait0} !== {1'b1, 1'b0, 16'h1234, 1'b1}) begin
      failures++;
      $display("FAIL read_ack got pdt=%b req=%b dout=%h w0=%b exp 1 0 1234 1", pdtack, mem_req, dout, npwait0);
    end
    bus_release();
    tick(2);
    checks++;
    if (pdtack !== 1'b1) begin failures++; $display("FAIL read_hold got pdt=%b exp=1", pdtack); end
    tick();
    checks++;
    if ({pdtack, dout} !== {1'b0, 16'h1234}) begin
      failures++; $display("FAIL read_release got pdt=%b dout=%h exp 0 1234", pdtack, dout);
    end
    tick();
  endtask

  task automatic test_byte_write();
    addr = 19'd5; rw = 1'b0; din = 16'hAB00; nuds = 1'b0; nlds = 1'b1; nzone = 1'b0; nas = 1'b0;
    tick(3);
    checks++;
    if ({mem_req, mem_we, mem_be, mem_wdata, mem_addr} !== {1'b1, 1'b1, 2'b10, 16'hAB00, 19'd5}) begin
      failures++;
      $display("FAIL write_req got req=%b we=%b be=%b wd=%h addr=%h exp 1 1 10 ab00 00005",
               mem_req, mem_we, mem_be, mem_wdata, mem_addr);
    end
    din = 16'h0000;
    tick();
    mem_ack = 1'b1; mem_rdata = 16'h5555;
    tick();
    mem_ack = 1'b0;
    checks++;
    if ({pdtack, mem_req, dout, mem_wdata} !== {1'b1, 1'b0, 16'h1234, 16'hAB00}) begin
      failures++;
      $display("FAIL write_ack got pdt=%b req=%b dout=%h wd=%h exp 1 0 1234 ab00", pdtack, mem_req, dout, mem_wdata);
    end
    bus_release();
    tick(4);
  endtask

  task automatic test_no_cycle();
    int bad = 0;
    nzone = 1'b1; nuds = 1'b0; nlds = 1'b0; nas = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if ({mem_req, npwait1, npwait0} !== 3'b011) bad++;
    end
    checks++;
    if (bad != 0) begin failures++; $display("FAIL no_zone got bad_cycles=%0d exp=0", bad); end
    bad = 0;
    nzone = 1'b0; nuds = 1'b1; nlds = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      if ({mem_req, npwait1, npwait0} !== 3'b011) bad++;
    end
    checks++;
    if (bad != 0) begin failures++; $display("FAIL no_strobe got bad_cycles=%0d exp=0", bad); end
    bus_release();
    tick(3);
  endtask

  task automatic test_abort();
    int bad = 0;
    addr = 19'd9; rw = 1'b1; nuds = 1'b0; nlds = 1'b0; nzone = 1'b0; nas = 1'b0;
    tick(4);
    bus_release();
    for (int i = 0; i < 4; i++) begin
      tick();
      if ({mem_req, pdtack, npwait0, to_err} !== 4'b1000) bad++;
    end
    checks++;
    if (bad != 0) begin failures++; $display("FAIL abort_hold_req got bad_cycles=%0d exp=0", bad); end
    mem_ack = 1'b1; mem_rdata = 16'hDEAD;
    tick();
    mem_ack = 1'b0;
    checks++;
    if ({mem_req, pdtack, npwait0, dout} !== {1'b0, 1'b0, 1'b1, 16'h1234}) begin
      failures++;
      $display("FAIL abort_end got req=%b pdt=%b w0=%b dout=%h exp 0 0 1 1234", mem_req, pdtack, npwait0, dout);
    end
    tick(2);
    checks++;
    if ({mem_req, pdtack} !== 2'b00) begin failures++; $display("FAIL abort_idle got req/pdt=%b exp=00", {mem_req, pdtack}); end
  endtask

  task automatic test_ack_vs_release();
    rw = 1'b1; nuds = 1'b0; nlds = 1'b0; nzone = 1'b0; nas = 1'b0;
    tick(4);
    bus_release();
    tick(2);
    mem_ack = 1'b1; mem_rdata = 16'h0BEE;
    tick();
    mem_ack = 1'b0;
    checks++;
    if ({pdtack, dout} !== {1'b1, 16'h0BEE}) begin
      failures++; $display("FAIL race_ack_wins got pdt=%b dout=%h exp 1 0bee", pdtack, dout);
    end
    tick();
    checks++;
    if (pdtack !== 1'b0) begin failures++; $display("FAIL race_hold_exit got pdt=%b exp=0", pdtack); end
    tick();
  endtask

  task automatic test_reset_mid();
    addr = 19'd3; rw = 1'b1; nuds = 1'b0; nlds = 1'b0; nzone = 1'b0; nas = 1'b0;
    tick(5);
    #2 nreset = 1'b0;
    #1;
    checks++;
    if ({mem_req, pdtack, npwait0, mem_addr, mem_be, dout} !== {1'b0, 1'b0, 1'b1, 19'd0, 2'b00, 16'd0}) begin
      failures++;
      $display("FAIL reset_async got req=%b pdt=%b w0=%b addr=%h be=%b dout=%h exp 0 0 1 0 00 0000",
               mem_req, pdtack, npwait0, mem_addr, mem_be, dout);
    end
    bus_release();
    tick();
    nreset = 1'b1;
    tick();
    mem_ack = 1'b1; mem_rdata = 16'h7777;
    tick();
    mem_ack = 1'b0;
    tick();
    checks++;
    if ({mem_req, pdtack, dout} !== {1'b0, 1'b0, 16'd0}) begin
      failures++; $display("FAIL late_ack got req=%b pdt=%b dout=%h exp 0 0 0000", mem_req, pdtack, dout);
    end
  endtask

  task automatic test_timeout();
`ifdef PORT_TIMEOUT_EN
    rw = 1'b1; nuds = 1'b0; nlds = 1'b0; nzone = 1'b0; nas = 1'b0;
    tick(11);
    checks++;
    if ({mem_req, to_err} !== 2'b10) begin failures++; $display("FAIL timeout_before got req/to=%b exp=10", {mem_req, to_err}); end
    tick();
    checks++;
    if ({to_err, pdtack, mem_req, dout} !== {1'b1, 1'b1, 1'b0, 16'hFFFF}) begin
      failures++; $display("FAIL timeout_fire got to=%b pdt=%b req=%b dout=%h exp 1 1 0 ffff", to_err, pdtack, mem_req, dout);
    end
    tick();
    checks++;
    if (to_err !== 1'b0) begin failures++; $display("FAIL timeout_pulse got=%b exp=0", to_err); end
    bus_release();
    tick(4);
`else
    int bad = 0;
    rw = 1'b1; nuds = 1'b0; nlds = 1'b0; nzone = 1'b0; nas = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (to_err !== 1'b0 || (i >= 2 && mem_req !== 1'b1)) bad++;
    end
    checks++;
    if (bad != 0) begin failures++; $display("FAIL no_timeout got bad_cycles=%0d exp=0", bad); end
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    bus_release();
    tick(4);
`endif
  endtask

  initial begin
    test_reset();
    test_read();
    test_byte_write();
    test_no_cycle();
    test_abort();
    test_ack_vs_release();
    test_reset_mid();
    test_timeout();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/port_zone_bridge.md
Name: port_zone_bridge

Overview:
- Sits directly upstream of the 68K DTACK/wait generator.
- Turns 68K accesses to the cartridge PORT zone (0x200000-0x2FFFFF) into a req/ack transaction on the memory arbiter (SDRAM-backed cart data).
- Drives the PORT wait-select pins and PDTACK that the DTACK generator consumes, and returns read data to the 68K data mux.

Parameters:
- ADDR_W, 19: word-address width inside the PORT zone (M68K_ADDR[19:1]).
- TIMEOUT, 1023: CLK cycles in WAIT_ACK before forced completion (only with PORT_TIMEOUT_EN).
- TO_DATA, 16'hFFFF: read data returned on timeout.

Ports:
- CLK  in  1  system clock (all logic on rising edge)
- nRESET  in  1  asynchronous active-low reset
- nAS  in  1  68K address strobe, asynchronous to CLK
- RW  in  1  68K read(1)/write(0)
- nUDS  in  1  upper data strobe
- nLDS  in  1  lower data strobe
- nPORT_ZONE  in  1  PORT zone decode, active low
- M68K_ADDR  in  ADDR_W  word address
- M68K_DATA_IN  in  16  CPU write data
- PORT_DATA_OUT  out  16  read data to 68K data mux
- MEM_REQ  out  1  level request to arbiter
- MEM_WE  out  1  1=write
- MEM_ADDR  out  ADDR_W  latched word address
- MEM_WDATA  out  16  latched write data
- MEM_BE  out  2  {upper,lower} byte enables
- MEM_ACK  in  1  one-cycle completion pulse
- MEM_RDATA  in  16  valid in the MEM_ACK cycle
- PDTACK  out  1  PORT transfer done, active high
- nPWAIT0  out  1  PORT wait select bit 0
- nPWAIT1  out  1  PORT wait select bit 1
- TIMEOUT_ERR  out  1  one-cycle pulse on forced completion

Behaviour:
- Reset values: MEM_REQ=0, MEM_WE=0, MEM_ADDR=0, MEM_WDATA=0, MEM_BE=0, PDTACK=0, PORT_DATA_OUT=0, nPWAIT1=1, nPWAIT0=1, TIMEOUT_ERR=0. FSM goes to IDLE.
- Reset acts immediately, mid-transaction included. An outstanding MEM_ACK arriving after reset release is ignored in IDLE.
- Synchronisation: nAS, RW, nUDS, nLDS and nPORT_ZONE each pass through a 2-flop synchroniser. Address and data are sampled only at the start event, when they are stable.
- Start event: in IDLE, synced nAS=0 AND synced nPORT_ZONE=0 AND (synced nUDS=0 OR synced nLDS=0). Strobes both high means no cycle and IDLE holds.
- States:
  - IDLE -> REQ on start. Latch MEM_ADDR, MEM_WE=~RW, MEM_BE={~nUDS,~nLDS}, MEM_WDATA (writes only).
  - REQ: MEM_REQ=1 (asserted the cycle after the start event). Go to WAIT_ACK.
  - WAIT_ACK: hold MEM_REQ=1 until MEM_ACK.
    - On MEM_ACK: MEM_REQ=0 next cycle. For reads, latch MEM_RDATA into PORT_DATA_OUT. Go to HOLD.
    - If synced nAS rises first: go to ABORT.
  - HOLD: PDTACK=1. Leave when synced nAS=1: PDTACK=0 in the same registered update, go to IDLE.
  - ABORT: keep MEM_REQ=1 until MEM_ACK, discard data, never assert PDTACK, then IDLE.
- Latency: nAS low to MEM_REQ high is 3 CLK edges (2 synchroniser + 1 FSM). MEM_ACK to PDTACK high is 1 edge.
- nPWAIT1/nPWAIT0 = 1/0 (maximum wait select) from REQ through WAIT_ACK and ABORT; 1/1 in IDLE and HOLD.
- MEM_ACK in the same cycle as nAS rising in WAIT_ACK: the ack wins, go to HOLD. HOLD exits on the next edge because nAS is already high.
- PORT_DATA_OUT holds its last value after a write or abort and updates only on read acks.
- Back-to-back cycles: a new start cannot be accepted until HOLD/ABORT return to IDLE, so there is at least 1 idle cycle between requests.

Optional Feature:
- PORT_TIMEOUT_EN defined:
  - 10-bit counter cleared on REQ entry, incremented each WAIT_ACK/ABORT cycle.
  - When it reaches TIMEOUT without MEM_ACK: MEM_REQ=0, TIMEOUT_ERR pulses 1 cycle.
  - From WAIT_ACK: go to HOLD; for reads PORT_DATA_OUT=TO_DATA.
  - From ABORT: go to IDLE.
- Undefined: no counter; WAIT_ACK/ABORT wait indefinitely; TIMEOUT_ERR tied 0.

Test Plan:
- Read 0x200002 (addr 1), both strobes low, MEM_ACK 5 cycles after REQ with RDATA=16'h1234 -> MEM_REQ high on edge 3, MEM_BE=2'b11, MEM_WE=0, PORT_DATA_OUT=16'h1234, PDTACK=1 one edge after ack, low when nAS rises.
- Byte write nUDS=0/nLDS=1, data 16'hAB00 -> MEM_WE=1, MEM_BE=2'b10, MEM_WDATA=16'hAB00, PORT_DATA_OUT unchanged.
- nAS low with nPORT_ZONE=1, or both strobes high -> MEM_REQ stays 0, nPWAIT pins stay 1/1.
- nAS rises in WAIT_ACK, ack 4 cycles later -> MEM_REQ held to ack, PDTACK never 1, returns to IDLE.
- nRESET low during WAIT_ACK -> all outputs at reset values immediately; late MEM_ACK after release ignored.
- With PORT_TIMEOUT_EN and TIMEOUT=8, no ack on a read -> TIMEOUT_ERR pulse after 8 WAIT_ACK cycles, PORT_DATA_OUT=16'hFFFF, PDTACK=1.
